// File: rtl/t_counter_ctrl.sv
// rtl/t_counter_ctrl.sv - toggle-bank up/down counter controller with start/pause/stop sequencing
// Optional prescaler built only when TCC_PRESCALE_EN is defined.
module t_counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             DIR,
  input  logic             RELOAD,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] T_VEC,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;

  logic [WIDTH-1:0] step_vec;
  logic             carry;
  logic [WIDTH-1:0] start_val_q;
  logic [WIDTH-1:0] end_val_q;
  logic [WIDTH-1:0] launch_val;
  logic [WIDTH-1:0] t_vec;
  logic             tc;
  logic             launch;
  logic             tick;

`ifdef TCC_PRESCALE_EN
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PSW-1:0] ps_q, ps_d;

  // Tick once per PRESCALE RUN cycles
  always_comb begin
    tick = (ps_q == PSW'(PRESCALE - 1));
  end

  // Prescale counter: clears on launch/stop, advances in RUN, holds elsewhere
  always_comb begin
    ps_d = ps_q;
    if (STOP || launch) begin
      ps_d = '0;
    end else if (state_q == ST_RUN) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
  end

  // Prescale counter register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  // Without the prescaler every RUN cycle is a tick; PRESCALE must still be legal
  always_comb begin
    tick = (PRESCALE >= 1);
  end
`endif

  // Launch/terminal values derived from the latched configuration
  always_comb begin
    start_val_q = dir_q ? limit_q : '0;
    end_val_q   = dir_q ? '0 : limit_q;
    launch_val  = DIR ? LIMIT : '0;
  end

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    step_vec = '0;
    carry    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_vec[i] = carry;
      carry       = carry & (dir_q ? ~count_q[i] : count_q[i]);
    end
  end

  // Sequencer: STOP beats START beats PAUSE; terminal one-shot goes to DONE
  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    t_vec    = '0;
    tc       = 1'b0;
    launch   = 1'b0;
    if (STOP) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            launch = 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (count_q == end_val_q) begin
              tc = 1'b1;
              if (reload_q) begin
                t_vec = count_q ^ start_val_q;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              t_vec = step_vec;
            end
          end
          if (PAUSE && (state_d == ST_RUN)) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!PAUSE) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (launch) begin
      state_d  = ST_RUN;
      limit_d  = LIMIT;
      dir_d    = DIR;
      reload_d = RELOAD;
    end
    count_d = launch ? launch_val : (count_q ^ t_vec);
  end

  // State, bank and latched configuration registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
    end
  end

  // Output mapping
  always_comb begin
    T_VEC = t_vec;
    COUNT = count_q;
    TC    = tc;
    BUSY  = (state_q == ST_RUN) || (state_q == ST_HOLD);
    DONE  = (state_q == ST_DONE);
    STATE = state_q;
  end

endmodule

// File: tb/tb_t_counter_ctrl.sv
// tb/tb_t_counter_ctrl.sv - self-checking bench for t_counter_ctrl
module tb_t_counter_ctrl;

`ifdef TCC_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0, STOP = 1'b0, PAUSE = 1'b0, DIR = 1'b0, RELOAD = 1'b0;
  logic [7:0] LIMIT = 8'd0;
  logic [7:0] T_VEC, COUNT;
  logic       TC, BUSY, DONE;
  logic [1:0] STATE;

  t_counter_ctrl #(.WIDTH(8), .PRESCALE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .DIR(DIR), .RELOAD(RELOAD), .LIMIT(LIMIT), .T_VEC(T_VEC), .COUNT(COUNT),
    .TC(TC), .BUSY(BUSY), .DONE(DONE), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       st, sp, pa, dr, rl;
    logic [7:0] lim;
    logic [7:0] count, tvec;
    logic       tc;
    logic [1:0] state;
  } vec_t;

  typedef struct {
    logic [7:0] count, tvec;
    logic       tc;
    logic [1:0] state;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  logic [1:0] cur_state;
  logic [7:0] cur_count;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic void add(input logic st, sp, pa, dr, rl, input logic [7:0] lim,
                              input logic [7:0] cnt, tv, input logic tcx, input logic [1:0] stx);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.dr = dr; v.rl = rl; v.lim = lim;
    v.count = cnt; v.tvec = tv; v.tc = tcx; v.state = stx;
    vecs.push_back(v);
  endfunction

  task automatic cycle(input logic st, sp, pa, dr, rl, input logic [7:0] lim,
                       input logic [7:0] ecnt, etv, input logic etc, input logic [1:0] est);
    exp_t e;
    @(negedge CLK);
    START = st; STOP = sp; PAUSE = pa; DIR = dr; RELOAD = rl; LIMIT = lim;
    e.count = ecnt; e.tvec = etv; e.tc = etc; e.state = est; e.idx = ncyc;
    sb.push_back(e);
    ncyc++;
    #1;
    e = sb.pop_front();
    chk("COUNT", e.idx, COUNT, e.count);
    chk("T_VEC", e.idx, T_VEC, e.tvec);
    chk("TC",    e.idx, {7'd0, TC}, {7'd0, e.tc});
    chk("STATE", e.idx, {6'd0, STATE}, {6'd0, e.state});
    chk("BUSY",  e.idx, {7'd0, BUSY}, {7'd0, (e.state == 2'b01) || (e.state == 2'b10)});
    chk("DONE",  e.idx, {7'd0, DONE}, {7'd0, e.state == 2'b11});
  endtask

  // Launch an up one-shot count to lim and follow it to DONE with an arithmetic model
  task automatic run_up(input logic [7:0] lim);
    cycle(1, 0, 0, 0, 0, lim, cur_count, 8'h00, 0, cur_state);
    for (int c = 0; c <= int'(lim); c++) begin
      for (int p = 0; p < PS; p++) begin
        logic last;
        last = (p == PS - 1);
        cycle(0, 0, 0, 0, 0, lim, 8'(c),
              (last && c != int'(lim)) ? 8'(c ^ (c + 1)) : 8'h00,
              last && (c == int'(lim)), 2'b01);
      end
    end
    cycle(0, 0, 0, 0, 0, lim, lim, 8'h00, 0, 2'b11);
    cycle(0, 0, 0, 0, 0, 8'h55, lim, 8'h00, 0, 2'b11);
    cur_state = 2'b11;
    cur_count = lim;
  endtask

  initial begin
    #3;
    chk("rst COUNT", -1, COUNT, 8'h00);
    chk("rst T_VEC", -1, T_VEC, 8'h00);
    chk("rst STATE", -1, {6'd0, STATE}, 8'h00);
    chk("rst BUSY/DONE/TC", -1, {5'd0, BUSY, DONE, TC}, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    cur_state = 2'b00;
    cur_count = 8'h00;

`ifndef TCC_PRESCALE_EN
    //   st sp pa dr rl lim    count  tvec  tc state
    // up one-shot to 3
    add(1, 0, 0, 0, 0, 8'd3,  8'h00, 8'h00, 0, 2'b00);
    add(0, 0, 0, 0, 0, 8'd3,  8'h00, 8'h01, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd3,  8'h01, 8'h03, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd3,  8'h02, 8'h01, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd3,  8'h03, 8'h00, 1, 2'b01);
    add(0, 0, 0, 0, 0, 8'd3,  8'h03, 8'h00, 0, 2'b11);
    add(0, 0, 0, 0, 0, 8'd3,  8'h03, 8'h00, 0, 2'b11);
    // down reload from 2, relaunched from DONE; LIMIT change mid-run ignored
    add(1, 0, 0, 1, 1, 8'd2,  8'h03, 8'h00, 0, 2'b11);
    add(0, 0, 0, 0, 0, 8'd2,  8'h02, 8'h03, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd2,  8'h01, 8'h01, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd2,  8'h00, 8'h02, 1, 2'b01);
    add(0, 0, 0, 0, 0, 8'd5,  8'h02, 8'h03, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd5,  8'h01, 8'h01, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd5,  8'h00, 8'h02, 1, 2'b01);
    add(0, 1, 0, 0, 0, 8'd5,  8'h02, 8'h00, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd5,  8'h02, 8'h00, 0, 2'b00);
    // up to 10 with a pause at 4 and a stop at 7
    add(1, 0, 0, 0, 0, 8'd10, 8'h02, 8'h00, 0, 2'b00);
    add(0, 0, 0, 0, 0, 8'd10, 8'h00, 8'h01, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd10, 8'h01, 8'h03, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd10, 8'h02, 8'h01, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd10, 8'h03, 8'h07, 0, 2'b01);
    add(0, 0, 1, 0, 0, 8'd10, 8'h04, 8'h01, 0, 2'b01);
    add(0, 0, 1, 0, 0, 8'd10, 8'h05, 8'h00, 0, 2'b10);
    add(1, 0, 1, 0, 0, 8'd10, 8'h05, 8'h00, 0, 2'b10);
    add(0, 0, 0, 0, 0, 8'd10, 8'h05, 8'h00, 0, 2'b10);
    add(0, 0, 0, 0, 0, 8'd10, 8'h05, 8'h03, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd10, 8'h06, 8'h01, 0, 2'b01);
    add(0, 1, 0, 0, 0, 8'd10, 8'h07, 8'h00, 0, 2'b01);
    add(0, 0, 0, 0, 0, 8'd10, 8'h07, 8'h00, 0, 2'b00);
    add(1, 1, 0, 0, 0, 8'd10, 8'h07, 8'h00, 0, 2'b00);
    add(0, 0, 0, 0, 0, 8'd10, 8'h07, 8'h00, 0, 2'b00);
    // LIMIT=0 one-shot: terminal in the first RUN cycle
    add(1, 0, 0, 0, 0, 8'd0,  8'h07, 8'h00, 0, 2'b00);
    add(0, 0, 0, 0, 0, 8'd0,  8'h00, 8'h00, 1, 2'b01);
    add(0, 0, 0, 0, 0, 8'd0,  8'h00, 8'h00, 0, 2'b11);

    foreach (vecs[i]) begin
      cycle(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].dr, vecs[i].rl, vecs[i].lim,
            vecs[i].count, vecs[i].tvec, vecs[i].tc, vecs[i].state);
    end
    cur_state = 2'b11;
    cur_count = 8'h00;
`endif

    // Short up count: steps every PS cycles, TC one cycle wide
    run_up(8'd2);
    // Full-range up count: reaches FF and stops without wrapping
    run_up(8'hFF);

    // Asynchronous reset in the middle of a count at COUNT=5
    cycle(1, 0, 0, 0, 0, 8'd10, cur_count, 8'h00, 0, cur_state);
    for (int c = 0; c < 5; c++) begin
      for (int p = 0; p < PS; p++) begin
        cycle(0, 0, 0, 0, 0, 8'd10, 8'(c),
              (p == PS - 1) ? 8'(c ^ (c + 1)) : 8'h00, 0, 2'b01);
      end
    end
    @(negedge CLK);
    #1;
    chk("pre-rst COUNT", ncyc, COUNT, 8'h05);
    RST = 1'b1;
    #1;
    chk("midrst COUNT", ncyc, COUNT, 8'h00);
    chk("midrst STATE", ncyc, {6'd0, STATE}, 8'h00);
    chk("midrst BUSY", ncyc, {7'd0, BUSY}, 8'h00);
    chk("midrst T_VEC", ncyc, T_VEC, 8'h00);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    #1;
    chk("post-rst STATE", ncyc, {6'd0, STATE}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_counter_ctrl.md
Name: t_counter_ctrl

Overview:
Controller and sequencer for a bank of WIDTH toggle (T) flip-flop cells that form a programmable up/down counter. Each cycle it computes the per-bit toggle-enable vector T_VEC and applies it to the internal toggle bank (COUNT <= COUNT ^ T_VEC). A start/pause/stop FSM sequences the bank, and terminal-count detection drives one-shot or auto-reload operation. Sits between the control logic and toggle-cell datapaths as the standard way to run a toggle bank as a timer or counter.

Parameters:
WIDTH, 8, width of the toggle bank, LIMIT and COUNT (must be >= 1)
PRESCALE, 4, tick divisor used only when TCC_PRESCALE_EN is defined (must be >= 1)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  launch (from IDLE) or relaunch (from DONE) a count
STOP  input  1  abort to IDLE from any state; highest priority
PAUSE  input  1  level; RUN->HOLD while high
DIR  input  1  0 = up (0 -> LIMIT), 1 = down (LIMIT -> 0); sampled at launch
RELOAD  input  1  1 = auto-reload at terminal count, 0 = one-shot; sampled at launch
LIMIT  input  WIDTH  terminal/start value; sampled at launch
T_VEC  output  WIDTH  toggle enables applied to the bank this cycle (combinational)
COUNT  output  WIDTH  toggle bank state (registered)
TC  output  1  terminal-count pulse (combinational, one cycle per terminal event)
BUSY  output  1  high in RUN or HOLD
DONE  output  1  high in DONE
STATE  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset (async, immediate, including mid-count): STATE=IDLE; COUNT=0; latched LIMIT/DIR/RELOAD=0; prescale counter=0. Outputs: T_VEC=0, TC=0, BUSY=0, DONE=0.
- Launch value: S = 0 when DIR=0, S = LIMIT when DIR=1. Terminal value: E = LIMIT when DIR=0, E = 0 when DIR=1.
- IDLE, START=1 at edge k: latch LIMIT/DIR/RELOAD; COUNT <= S; STATE <= RUN. RUN is visible in the cycle after edge k.
- DONE, START=1: same launch action as from IDLE.
- RUN, tick=1, COUNT != E:
  - Up: T_VEC[0]=1, T_VEC[i] = AND(COUNT[i-1:0]).
  - Down: T_VEC[0]=1, T_VEC[i] = AND(~COUNT[i-1:0]).
  - COUNT <= COUNT ^ T_VEC.
- RUN, tick=1, COUNT == E: TC=1.
  - RELOAD=1: T_VEC = COUNT ^ S, so the bank returns to S at the edge; stay in RUN.
  - RELOAD=0: T_VEC=0, COUNT holds E; STATE <= DONE.
- Latched LIMIT=0: the first RUN cycle is already terminal, so TC=1 immediately.
- RUN, tick=0: T_VEC=0, TC=0.
- RUN with PAUSE=1: STATE <= HOLD. The pause takes effect at that edge; the current cycle's toggle still applies.
- HOLD: T_VEC=0, COUNT frozen. PAUSE=0 -> RUN.
- STOP=1 in any state: STATE <= IDLE; T_VEC forced 0; COUNT holds its value.
- Priority: STOP > START > PAUSE. START+STOP together -> IDLE. START in RUN/HOLD is ignored.
- DONE: T_VEC=0, holds until START or STOP.
- Latched LIMIT/DIR/RELOAD are frozen while BUSY. Input changes take effect only at the next launch.
- Wrap: there is no modulo-2^WIDTH wrap, because E always stops or reloads the bank first.

Optional Feature:
- Macro: TCC_PRESCALE_EN.
- Defined:
  - An internal counter PS runs 0..PRESCALE-1 in RUN; tick=1 only when PS == PRESCALE-1.
  - PS clears on launch and on STOP, and holds in HOLD.
  - COUNT advances once per PRESCALE RUN cycles.
- Undefined: tick=1 every RUN cycle; PRESCALE is ignored and no PS logic is built.

Test Plan:
- Reset mid-run: RST pulse between clock edges while COUNT=5 -> COUNT=0, STATE=00, BUSY=0 immediately, without waiting for an edge.
- Up one-shot: WIDTH=8, LIMIT=3, DIR=0, RELOAD=0, START 1 cycle ->
  - COUNT 0,1,2,3 on consecutive cycles;
  - T_VEC 01,03,01, then 00 in the terminal cycle;
  - TC high only in the COUNT=3 cycle;
  - then DONE=1, COUNT holds 3.
- Down reload: LIMIT=2, DIR=1, RELOAD=1 -> COUNT 2,1,0,2,1,0...; TC each time COUNT=0; T_VEC=02 in each terminal cycle; BUSY stays 1.
- Pause/stop: PAUSE high at COUNT=4 for 3 cycles -> COUNT frozen at 5, STATE=10, T_VEC=0. STOP at COUNT=7 -> IDLE, COUNT holds 7. START+STOP in the same cycle -> stays IDLE.
- Edge values: LIMIT=0, up, one-shot -> TC in the first RUN cycle, DONE next. LIMIT=FF, up, WIDTH=8 -> reaches FF, TC, no wrap to 00. LIMIT changed mid-run is ignored.
- TCC_PRESCALE_EN with PRESCALE=4, LIMIT=2, up -> COUNT changes every 4th RUN cycle; TC is one cycle wide at the 4th cycle of COUNT=2. Without the macro -> changes every cycle.
